// File: rtl/versioned_store.sv
// Multi-slot versioned data store: (tag, data) entries written over a valid/ready port,
// answered by snapshot reads returning the greatest tag at or below the requested version.
module versioned_store #(
    parameter int DATA_WIDTH      = 32,
    parameter int VERSION_WIDTH   = 4,
    parameter int VERSION_NUM     = 4,
    parameter bit MATCH_INCLUSIVE = 1'b1,
    parameter int CNT_WIDTH       = $clog2(VERSION_NUM + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wrValid,
    output logic                     wrReady,
    input  logic [VERSION_WIDTH-1:0] wrVersion,
    input  logic [DATA_WIDTH-1:0]    wrData,
    input  logic                     rdValid,
    output logic                     rdReady,
    input  logic [VERSION_WIDTH-1:0] rdVersion,
    output logic                     rdOutValid,
    input  logic                     rdOutReady,
    output logic                     rdOutHit,
    output logic [VERSION_WIDTH-1:0] rdOutVersion,
    output logic [DATA_WIDTH-1:0]    rdOutData,
    output logic [CNT_WIDTH-1:0]     occupancy
);

    localparam int IDX_W = (VERSION_NUM > 1) ? $clog2(VERSION_NUM) : 1;

    logic [VERSION_NUM-1:0]   r_valid;
    logic [VERSION_WIDTH-1:0] r_tag  [VERSION_NUM];
    logic [DATA_WIDTH-1:0]    r_data [VERSION_NUM];

    logic                     r_outValid;
    logic                     r_outHit;
    logic [VERSION_WIDTH-1:0] r_outVersion;
    logic [DATA_WIDTH-1:0]    r_outData;

    logic                     w_wrAccept;
    logic                     w_rdAccept;
    logic                     w_hitFound;
    logic [IDX_W-1:0]         w_hitIdx;
    logic                     w_freeFound;
    logic [IDX_W-1:0]         w_freeIdx;
    logic                     w_minFound;
    logic [IDX_W-1:0]         w_minIdx;
    logic [VERSION_WIDTH-1:0] w_minTag;
    logic [IDX_W-1:0]         w_wrIdx;
    logic                     w_bestFound;
    logic [IDX_W-1:0]         w_bestIdx;
    logic [VERSION_WIDTH-1:0] w_bestTag;
    logic [CNT_WIDTH-1:0]     w_occ;

    assign wrReady    = !flush;
    assign rdReady    = !r_outValid || rdOutReady;
    assign w_wrAccept = wrValid && wrReady;
    assign w_rdAccept = rdValid && rdReady;

    // Write target: existing tag first, then lowest free slot, else evict the oldest (smallest) tag.
    always_comb begin
        w_hitFound  = 1'b0;
        w_hitIdx    = '0;
        w_freeFound = 1'b0;
        w_freeIdx   = '0;
        w_minFound  = 1'b0;
        w_minIdx    = '0;
        w_minTag    = '0;
        for (int i = 0; i < VERSION_NUM; i++) begin
            if (r_valid[i] && (r_tag[i] == wrVersion)) begin
                w_hitFound = 1'b1;
                w_hitIdx   = IDX_W'(i);
            end
            if (!r_valid[i] && !w_freeFound) begin
                w_freeFound = 1'b1;
                w_freeIdx   = IDX_W'(i);
            end
            if (r_valid[i] && (!w_minFound || (r_tag[i] < w_minTag))) begin
                w_minFound = 1'b1;
                w_minIdx   = IDX_W'(i);
                w_minTag   = r_tag[i];
            end
        end
        if (w_hitFound) begin
            w_wrIdx = w_hitIdx;
        end else if (w_freeFound) begin
            w_wrIdx = w_freeIdx;
        end else begin
            w_wrIdx = w_minIdx;
        end
    end

    always_comb begin
        w_bestFound = 1'b0;
        w_bestIdx   = '0;
        w_bestTag   = '0;
        for (int i = 0; i < VERSION_NUM; i++) begin
            if (r_valid[i] &&
                (MATCH_INCLUSIVE ? (r_tag[i] <= rdVersion) : (r_tag[i] < rdVersion)) &&
                (!w_bestFound || (r_tag[i] > w_bestTag))) begin
                w_bestFound = 1'b1;
                w_bestIdx   = IDX_W'(i);
                w_bestTag   = r_tag[i];
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < VERSION_NUM; i++) begin
            w_occ = w_occ + CNT_WIDTH'(r_valid[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_wrAccept) begin
            r_valid[w_wrIdx] <= 1'b1;
        end
    end

    // Payload needs no reset: an invalid slot is never selected by either search.
    always_ff @(posedge clk) begin
        if (w_wrAccept) begin
            r_tag[w_wrIdx]  <= wrVersion;
            r_data[w_wrIdx] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid   <= 1'b0;
            r_outHit     <= 1'b0;
            r_outVersion <= '0;
            r_outData    <= '0;
        end else if (w_rdAccept) begin
            r_outValid   <= 1'b1;
            r_outHit     <= w_bestFound;
            r_outVersion <= w_bestFound ? r_tag[w_bestIdx] : '0;
            r_outData    <= w_bestFound ? r_data[w_bestIdx] : '0;
        end else if (rdOutReady) begin
            r_outValid   <= 1'b0;
        end
    end

    assign rdOutValid   = r_outValid;
    assign rdOutHit     = r_outHit;
    assign rdOutVersion = r_outVersion;
    assign rdOutData    = r_outData;
    assign occupancy    = w_occ;

endmodule

// File: tb/tb_versioned_store.sv
// Bench for versioned_store: an inclusive and an exclusive instance share all stimulus
// and are compared against a tag-indexed set model of the store.
module tb_versioned_store;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wrValid = 1'b0;
    logic [3:0]  wrVersion = '0;
    logic [31:0] wrData = '0;
    logic        rdValid = 1'b0;
    logic [3:0]  rdVersion = '0;
    logic        rdOutReady = 1'b1;

    logic        wrReadyI, rdReadyI, outValidI, outHitI;
    logic [3:0]  outVerI;
    logic [31:0] outDataI;
    logic [2:0]  occI;
    logic        wrReadyX, rdReadyX, outValidX, outHitX;
    logic [3:0]  outVerX;
    logic [31:0] outDataX;
    logic [2:0]  occX;

    logic [37:0] resp [2];
    logic [2:0]  occ [2];
    logic        rdRdy [2];
    logic        wrRdy [2];

    int errors = 0;
    int checks = 0;

    localparam logic [37:0] MISS = {1'b1, 37'd0};

    // Reference: one presence bit per tag value, plus the response register contents.
    bit          present [16];
    logic [31:0] mdata [16];
    int          mcount;
    bit          eV;
    bit          eH [2];
    logic [3:0]  eVer [2];
    logic [31:0] eD [2];

    always #5 clk = ~clk;

    versioned_store #(.DATA_WIDTH(32), .VERSION_WIDTH(4), .VERSION_NUM(4), .MATCH_INCLUSIVE(1'b1)) dutI (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wrValid(wrValid), .wrReady(wrReadyI), .wrVersion(wrVersion), .wrData(wrData),
        .rdValid(rdValid), .rdReady(rdReadyI), .rdVersion(rdVersion),
        .rdOutValid(outValidI), .rdOutReady(rdOutReady), .rdOutHit(outHitI),
        .rdOutVersion(outVerI), .rdOutData(outDataI), .occupancy(occI)
    );

    versioned_store #(.DATA_WIDTH(32), .VERSION_WIDTH(4), .VERSION_NUM(4), .MATCH_INCLUSIVE(1'b0)) dutX (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wrValid(wrValid), .wrReady(wrReadyX), .wrVersion(wrVersion), .wrData(wrData),
        .rdValid(rdValid), .rdReady(rdReadyX), .rdVersion(rdVersion),
        .rdOutValid(outValidX), .rdOutReady(rdOutReady), .rdOutHit(outHitX),
        .rdOutVersion(outVerX), .rdOutData(outDataX), .occupancy(occX)
    );

    assign resp[0]  = {outValidI, outHitI, outVerI, outDataI};
    assign resp[1]  = {outValidX, outHitX, outVerX, outDataX};
    assign occ[0]   = occI;
    assign occ[1]   = occX;
    assign rdRdy[0] = rdReadyI;
    assign rdRdy[1] = rdReadyX;
    assign wrRdy[0] = wrReadyI;
    assign wrRdy[1] = wrReadyX;

    function automatic logic [37:0] mkHit(input logic [3:0] v, input logic [31:0] d);
        return {1'b1, 1'b1, v, d};
    endfunction

    function automatic void modelClear();
        for (int t = 0; t < 16; t++) present[t] = 1'b0;
        mcount = 0;
    endfunction

    function automatic void modelReset();
        modelClear();
        eV = 1'b0;
        for (int k = 0; k < 2; k++) begin
            eH[k] = 1'b0;
            eVer[k] = '0;
            eD[k] = '0;
        end
    endfunction

    function automatic void modelWrite(input logic [3:0] t, input logic [31:0] d);
        bit evicted;
        evicted = 1'b0;
        if (!present[t]) begin
            if (mcount == 4) begin
                for (int k = 0; k < 16; k++) begin
                    if (present[k] && !evicted) begin
                        present[k] = 1'b0;
                        evicted = 1'b1;
                    end
                end
                mcount--;
            end
            present[t] = 1'b1;
            mcount++;
        end
        mdata[t] = d;
    endfunction

    function automatic void modelLookup(input bit inclusive, input logic [3:0] v,
                                        output bit hit, output logic [3:0] ver, output logic [31:0] d);
        hit = 1'b0;
        ver = '0;
        d = '0;
        for (int t = 15; t >= 0; t--) begin
            if (!hit && present[t] && (inclusive ? (t <= int'(v)) : (t < int'(v)))) begin
                hit = 1'b1;
                ver = 4'(t);
                d = mdata[t];
            end
        end
    endfunction

    task automatic tick();
        bit acc;
        bit h;
        logic [3:0] v;
        logic [31:0] d;
        acc = rdValid && (!eV || rdOutReady);
        @(posedge clk);
        if (acc) begin
            for (int k = 0; k < 2; k++) begin
                modelLookup(k == 0, rdVersion, h, v, d);
                eH[k] = h;
                eVer[k] = v;
                eD[k] = d;
            end
            eV = 1'b1;
        end else if (rdOutReady) begin
            eV = 1'b0;
        end
        if (flush) modelClear();
        else if (wrValid) modelWrite(wrVersion, wrData);
        #1;
    endtask

    task automatic doWrite(input logic [3:0] t, input logic [31:0] d);
        wrValid = 1'b1;
        wrVersion = t;
        wrData = d;
        tick();
        wrValid = 1'b0;
    endtask

    task automatic doRead(input logic [3:0] v);
        rdValid = 1'b1;
        rdVersion = v;
        tick();
        rdValid = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        flush = 1'b0;
        wrValid = 1'b0;
        rdValid = 1'b0;
        rdOutReady = 1'b1;
        modelReset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        modelReset();
        #2;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (resp[k] !== 38'd0 || occ[k] !== 3'd0)
                $display("[TB] FAIL reset_state dut%0d: got resp=%h occ=%0d want resp=0 occ=0", k, resp[k], occ[k]);
            if (resp[k] !== 38'd0 || occ[k] !== 3'd0) errors++;
        end
        rst_n = 1'b1;
        doRead(4'd7);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (resp[k] !== MISS || occ[k] !== 3'd0) begin
                errors++;
                $display("[TB] FAIL empty_read dut%0d: got resp=%h occ=%0d want resp=%h occ=0", k, resp[k], occ[k], MISS);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (resp[k][37] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL valid_drop dut%0d: got valid=%b want 0", k, resp[k][37]);
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0]  rv [4];
        logic [37:0] expT [2][4];
        rv[0] = 4'd6; rv[1] = 4'd9; rv[2] = 4'd1; rv[3] = 4'd2;
        expT[0][0] = mkHit(4'd5, 32'hB); expT[0][1] = mkHit(4'd9, 32'hC);
        expT[0][2] = MISS;               expT[0][3] = mkHit(4'd2, 32'hA);
        expT[1][0] = mkHit(4'd5, 32'hB); expT[1][1] = mkHit(4'd5, 32'hB);
        expT[1][2] = MISS;               expT[1][3] = MISS;
        doReset();
        doWrite(4'd2, 32'hA);
        doWrite(4'd5, 32'hB);
        doWrite(4'd9, 32'hC);
        for (int i = 0; i < 4; i++) begin
            doRead(rv[i]);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (resp[k] !== expT[k][i]) begin
                    errors++;
                    $display("[TB] FAIL basic_read%0d dut%0d: got %h want %h", rv[i], k, resp[k], expT[k][i]);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (occ[k] !== 3'd3) begin
                errors++;
                $display("[TB] FAIL basic_occ dut%0d: got %0d want 3", k, occ[k]);
            end
        end
    endtask

    task automatic test_evict();
        logic [37:0] expT [2][3];
        logic [3:0]  rv [3];
        doReset();
        doWrite(4'd3, 32'h33);
        doWrite(4'd1, 32'h11);
        doWrite(4'd8, 32'h88);
        doWrite(4'd6, 32'h66);
        doWrite(4'd7, 32'hD);
        rv[0] = 4'd2; rv[1] = 4'd7; rv[2] = 4'd15;
        expT[0][0] = MISS; expT[0][1] = mkHit(4'd7, 32'hD);  expT[0][2] = mkHit(4'd8, 32'hE);
        expT[1][0] = MISS; expT[1][1] = mkHit(4'd6, 32'h66); expT[1][2] = mkHit(4'd8, 32'hE);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) doWrite(4'd8, 32'hE);
            doRead(rv[i]);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (resp[k] !== expT[k][i] || occ[k] !== 3'd4) begin
                    errors++;
                    $display("[TB] FAIL evict_read%0d dut%0d: got resp=%h occ=%0d want resp=%h occ=4",
                             rv[i], k, resp[k], occ[k], expT[k][i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        rdOutReady = 1'b0;
        rdValid = 1'b1;
        rdVersion = 4'd4;
        tick();
        rdVersion = 4'd9;
        wrValid = 1'b1;
        wrVersion = 4'd3;
        wrData = 32'h30;
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rdRdy[k] !== 1'b0 || resp[k] !== MISS) begin
                    errors++;
                    $display("[TB] FAIL hold_c%0d dut%0d: got rdReady=%b resp=%h want rdReady=0 resp=%h",
                             c, k, rdRdy[k], resp[k], MISS);
                end
            end
            tick();
            wrValid = 1'b0;
        end
        rdOutReady = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rdRdy[k] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL release_ready dut%0d: got %b want 1", k, rdRdy[k]);
            end
        end
        tick();
        rdValid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (resp[k] !== mkHit(4'd3, 32'h30)) begin
                errors++;
                $display("[TB] FAIL release_read dut%0d: got %h want %h", k, resp[k], mkHit(4'd3, 32'h30));
            end
        end
        doReset();
        wrValid = 1'b1;
        wrVersion = 4'd4;
        wrData = 32'hF;
        doRead(4'd4);
        wrValid = 1'b0;
        checks++;
        if (resp[0] !== MISS) begin
            errors++;
            $display("[TB] FAIL same_cycle_wr_rd: got %h want %h", resp[0], MISS);
        end
        doRead(4'd4);
        checks++;
        if (resp[0] !== mkHit(4'd4, 32'hF)) begin
            errors++;
            $display("[TB] FAIL read_after_wr: got %h want %h", resp[0], mkHit(4'd4, 32'hF));
        end
    endtask

    task automatic test_flush();
        doReset();
        doWrite(4'd5, 32'h55);
        doWrite(4'd10, 32'hAA);
        flush = 1'b1;
        wrValid = 1'b1;
        wrVersion = 4'd12;
        wrData = 32'hCC;
        rdValid = 1'b1;
        rdVersion = 4'd15;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (wrRdy[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flush_wrready dut%0d: got %b want 0", k, wrRdy[k]);
            end
        end
        tick();
        flush = 1'b0;
        wrValid = 1'b0;
        rdValid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (resp[k] !== mkHit(4'd10, 32'hAA) || occ[k] !== 3'd0) begin
                errors++;
                $display("[TB] FAIL flush_read dut%0d: got resp=%h occ=%0d want resp=%h occ=0",
                         k, resp[k], occ[k], mkHit(4'd10, 32'hAA));
            end
        end
        doRead(4'd15);
        checks++;
        if (resp[0] !== MISS) begin
            errors++;
            $display("[TB] FAIL post_flush_read: got %h want %h", resp[0], MISS);
        end
    endtask

    task automatic test_reset_mid();
        doWrite(4'd6, 32'h66);
        rdOutReady = 1'b0;
        doRead(4'd7);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (resp[k][37] !== 1'b0 || occ[k] !== 3'd0) begin
                errors++;
                $display("[TB] FAIL async_reset dut%0d: got valid=%b occ=%0d want valid=0 occ=0",
                         k, resp[k][37], occ[k]);
            end
        end
        modelReset();
        rst_n = 1'b1;
        rdOutReady = 1'b1;
        doRead(4'd15);
        checks++;
        if (resp[0] !== MISS) begin
            errors++;
            $display("[TB] FAIL reset_empty_read: got %h want %h", resp[0], MISS);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 600; c++) begin
            flush = ($urandom_range(0, 19) == 0);
            wrValid = ($urandom_range(0, 1) == 1);
            wrVersion = 4'($urandom_range(0, 15));
            wrData = $urandom;
            rdValid = ($urandom_range(0, 2) != 0);
            rdVersion = 4'($urandom_range(0, 15));
            rdOutReady = ($urandom_range(0, 3) != 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rdRdy[k] !== (!eV || rdOutReady) || wrRdy[k] !== !flush) begin
                    errors++;
                    $display("[TB] FAIL rand_ready c%0d dut%0d: got rd=%b wr=%b want rd=%b wr=%b",
                             c, k, rdRdy[k], wrRdy[k], (!eV || rdOutReady), !flush);
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ((eV ? (resp[k] !== {1'b1, eH[k], eVer[k], eD[k]}) : (resp[k][37] !== 1'b0)) ||
                    occ[k] !== 3'(mcount)) begin
                    errors++;
                    $display("[TB] FAIL rand_resp c%0d dut%0d: got resp=%h occ=%0d want valid=%b resp=%h occ=%0d",
                             c, k, resp[k], occ[k], eV, {1'b1, eH[k], eVer[k], eD[k]}, mcount);
                end
            end
        end
        flush = 1'b0;
        wrValid = 1'b0;
        rdValid = 1'b0;
        rdOutReady = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_evict();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
